// File: rtl/irq_controller_if.sv
// MMIO register window of the interrupt controller.
// Bridge drives addr/we/wdata, controller returns rdata.
interface irq_controller_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller feeding CP0 HWInt: edge/level latching,
// enable mask, fixed priority, single in-service tracking with EOI.
module irq_controller #(
  parameter int          NSRC     = 6,
  parameter logic [5:0]  RST_MODE = 6'b000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] src,
  input  logic       int_ack,
  irq_controller_if.slave bus,
  output logic [5:0] hwint,
  output logic       in_service,
  output logic [2:0] irq_id
);

  localparam logic [5:0] MASK = 6'((7'd1 << NSRC) - 7'd1);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE
  } state_t;

  state_t     state;
  logic [5:0] enable;
  logic [5:0] mode;
  logic [5:0] pending;
  logic [5:0] src_d;

  logic       wr_en;
  logic       wr_mode;
  logic [5:0] w1c;
  logic       eoi;
  logic       ack;
  logic [2:0] ack_id;
  logic [5:0] ack_clr;
  logic [5:0] rise;
  logic [5:0] pend_n;
  logic [5:0] enable_n;
  logic [5:0] elig;
  logic [5:0] elig_n;
  logic       unused_wdata;

  assign unused_wdata = ^bus.wdata[31:6];

  // Highest set bit of the presented request vector.
  always_comb begin
    ack_id = '0;
    for (int i = 0; i < 6; i++) begin
      if (hwint[i]) ack_id = 3'(i);
    end
  end

  // Register writes, latching and next-state terms.
  always_comb begin
    wr_en    = bus.we && (bus.addr == 2'd0);
    wr_mode  = bus.we && (bus.addr == 2'd1);
    w1c      = (bus.we && (bus.addr == 2'd2)) ?
               bus.wdata[5:0] : 6'd0;
    eoi      = bus.we && (bus.addr == 2'd3) &&
               (state == SERVICE);
    ack      = int_ack && (state == ASSERT) &&
               (hwint != 6'd0);
    ack_clr  = (ack && mode[ack_id]) ?
               (6'd1 << ack_id) : 6'd0;
    rise     = src & ~src_d & enable;
    pend_n   = ((mode & (rise | (pending & ~w1c & ~ack_clr)))
               | (~mode & src & enable)) & MASK;
    enable_n = wr_en ? (bus.wdata[5:0] & MASK) : enable;
    elig     = pending & enable;
    elig_n   = pend_n & enable_n;
  end

  // Register read mux.
  always_comb begin
    bus.rdata = '0;
    unique case (bus.addr)
      2'd0: bus.rdata = {26'd0, enable};
      2'd1: bus.rdata = {26'd0, mode};
      2'd2: bus.rdata = {26'd0, pending};
      2'd3: bus.rdata = {in_service, 28'd0, irq_id};
      default: bus.rdata = '0;
    endcase
  end

  // Registers, request output and service FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      enable     <= '0;
      mode       <= RST_MODE & MASK;
      pending    <= '0;
      src_d      <= '0;
      hwint      <= '0;
      in_service <= 1'b0;
      irq_id     <= '0;
    end else begin
      enable  <= enable_n;
      if (wr_mode) mode <= bus.wdata[5:0] & MASK;
      pending <= pend_n;
      src_d   <= src & MASK;
      hwint   <= (state == SERVICE) ? 6'd0 : elig;
      unique case (state)
        IDLE: begin
          if (elig != 6'd0) state <= ASSERT;
        end
        ASSERT: begin
          if (ack) begin
            state      <= SERVICE;
            in_service <= 1'b1;
            irq_id     <= ack_id;
          end else if (elig == 6'd0) begin
            state <= IDLE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state      <= (elig_n != 6'd0) ? ASSERT : IDLE;
            in_service <= 1'b0;
            irq_id     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: expectations queued with
// stimulus, drained against DUT outputs and register reads.
module tb_irq_controller;

  localparam logic [5:0] RMODE = 6'h21;

  logic       clk;
  logic       reset;
  logic [5:0] src;
  logic       int_ack;
  logic [5:0] hwint;
  logic       in_service;
  logic [2:0] irq_id;

  irq_controller_if bus ();

  irq_controller #(
    .NSRC    (6),
    .RST_MODE(RMODE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src       (src),
    .int_ack   (int_ack),
    .bus       (bus.slave),
    .hwint     (hwint),
    .in_service(in_service),
    .irq_id    (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // sel: 0 hwint, 1 in_service, 2 irq_id, 4..7 register read
  task automatic push(input string tag, input int sel,
                      input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] got;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        0: got = {26'd0, hwint};
        1: got = {31'd0, in_service};
        2: got = {29'd0, irq_id};
        default: begin
          bus.addr = 2'(e.sel - 4);
          #1;
          got = bus.rdata;
        end
      endcase
      check(e.tag, got, e.exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    cyc(1);
    bus.we    = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    src       = '0;
    int_ack   = 1'b0;
    bus.addr  = '0;
    bus.we    = 1'b0;
    bus.wdata = '0;
    cyc(2);
    push("rst_hwint", 0, 0);
    push("rst_insvc", 1, 0);
    push("rst_id", 2, 0);
    push("rst_enable", 4, 0);
    push("rst_mode", 5, {26'd0, RMODE});
    push("rst_pending", 6, 0);
    drain();
    reset = 1'b1;
    cyc(1);

    // edge pulse on src[2]
    wr(2'd0, 32'h3F);
    wr(2'd1, 32'h3F);
    src = 6'h04;
    cyc(1);
    src = 6'h00;
    push("t1_pending", 6, 32'h04);
    push("t1_hwint_n1", 0, 0);
    drain();
    cyc(1);
    push("t1_hwint_n2", 0, 32'h04);
    drain();

    // priority capture and EOI
    wr(2'd2, 32'h04);
    cyc(2);
    src = 6'h12;
    cyc(1);
    src = 6'h00;
    cyc(1);
    push("t2_hwint", 0, 32'h12);
    drain();
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    cyc(1);
    push("t2_id", 2, 4);
    push("t2_insvc", 1, 1);
    push("t2_hwint_svc", 0, 0);
    push("t2_pending", 6, 32'h02);
    push("t2_isr", 7, 32'h8000_0004);
    drain();
    wr(2'd3, 32'h0);
    push("t2_eoi_insvc", 1, 0);
    push("t2_eoi_id", 2, 0);
    drain();
    cyc(1);
    push("t2_hwint_eoi", 0, 32'h02);
    drain();
    wr(2'd2, 32'h02);
    cyc(2);

    // level source on bit 3
    wr(2'd1, 32'h37);
    src = 6'h08;
    cyc(1);
    wr(2'd2, 32'h08);
    push("t3_w1c_level", 6, 32'h08);
    drain();
    cyc(1);
    push("t3_hwint", 0, 32'h08);
    drain();
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    cyc(1);
    push("t3_id", 2, 3);
    push("t3_hwint_svc", 0, 0);
    drain();
    wr(2'd3, 32'h0);
    push("t3_eoi_hwint", 0, 0);
    push("t3_eoi_insvc", 1, 0);
    drain();
    cyc(1);
    push("t3_reassert", 0, 32'h08);
    drain();
    src = 6'h00;
    cyc(1);
    push("t3_drop_pend", 6, 0);
    drain();
    cyc(1);
    push("t3_drop_hwint", 0, 0);
    drain();

    // set beats W1C, disable hides, spurious ack
    src       = 6'h01;
    bus.addr  = 2'd2;
    bus.wdata = 32'h01;
    bus.we    = 1'b1;
    cyc(1);
    bus.we    = 1'b0;
    src       = 6'h00;
    push("t4_set_wins", 6, 32'h01);
    drain();
    cyc(1);
    push("t4_hwint", 0, 32'h01);
    drain();
    wr(2'd0, 32'h3E);
    cyc(1);
    push("t4_dis_hwint", 0, 0);
    push("t4_dis_pend", 6, 32'h01);
    drain();
    wr(2'd0, 32'h3F);
    wr(2'd2, 32'h01);
    cyc(2);
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    cyc(1);
    push("t4_spur_insvc", 1, 0);
    push("t4_spur_hwint", 0, 0);
    drain();

    // ack+EOI together, then reset mid-service
    src = 6'h20;
    cyc(1);
    src = 6'h00;
    cyc(1);
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    push("t5_id", 2, 5);
    drain();
    int_ack = 1'b1;
    wr(2'd3, 32'h0);
    int_ack = 1'b0;
    push("t5_both_insvc", 1, 0);
    push("t5_both_id", 2, 0);
    drain();
    src = 6'h20;
    cyc(1);
    src = 6'h00;
    cyc(1);
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    push("t5_pre_insvc", 1, 1);
    drain();
    reset = 1'b0;
    #1;
    push("t5_rst_hwint", 0, 0);
    push("t5_rst_insvc", 1, 0);
    push("t5_rst_id", 2, 0);
    push("t5_rst_mode", 5, {26'd0, RMODE});
    push("t5_rst_enable", 4, 0);
    drain();
    reset = 1'b1;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
